fetch_fd_latch: RTL and testbench
=================================

Name: fetch_fd_latch

Overview:
- IF stage plus F/D pipeline latch for the 5-stage core.
- Owns the PC and drives the instruction memory address; produces the fd_inst word that hazard/bypass control decodes.
- Applies hold requests: the load-use control_stall from bypass control, and multdiv_busy.
- Applies flushes on taken branch/jump redirects from X.
- Keeps saturating stall/flush performance counters.

Parameters:
- ADDR_W, 12, PC / imem address width in words.
- RESET_PC, 0, PC value loaded on reset.
- NOP_WORD, 32'h00000000, word injected into FD on flush/boot.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- imem_addr  output  ADDR_W  current PC; equals pc register, combinational from it.
- imem_inst  input  32  instruction at imem_addr, combinational read, valid same cycle.
- control_stall  input  1  load-use stall from bypass control; hold PC and FD.
- multdiv_busy  input  1  multi-cycle mult/div in flight; hold PC and FD.
- redirect  input  1  taken branch/jump resolved in X; flush and retarget.
- redirect_pc  input  ADDR_W  target PC when redirect=1.
- fd_inst  output  32  instruction in FD latch.
- fd_pc  output  ADDR_W  PC+1 of the FD instruction (mod 2^ADDR_W), used for jal/branch.
- fd_valid  output  1  FD holds a real fetched instruction.
- halted  output  1  fetch stopped on HALT_WORD.
- stall_cycles  output  16  saturating count of hold cycles.
- flush_cycles  output  16  saturating count of redirect cycles.

Behaviour:
Reset (reset=0, asynchronous, takes effect immediately):
- pc=RESET_PC, fd_inst=NOP_WORD, fd_pc=0, fd_valid=0, halted=0, both counters 0, state=BOOT.
- Reset mid-operation discards everything.

State BOOT:
- Lasts exactly one clock edge after reset release.
- All inputs ignored; pc unchanged; FD keeps NOP, fd_valid=0.
- Next state is RUN.

State RUN, evaluated each edge with priority redirect > hold > advance:
- redirect=1: pc<=redirect_pc; fd_inst<=NOP_WORD; fd_valid<=0; fd_pc<=0; flush_cycles++. Overrides a simultaneous control_stall/multdiv_busy; stall_cycles is not incremented that cycle.
- hold (control_stall|multdiv_busy, redirect=0): pc, fd_inst, fd_pc, fd_valid unchanged; stall_cycles++.
- advance: fd_inst<=imem_inst; fd_pc<=pc+1; fd_valid<=1; pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
- advance with imem_inst==HALT_WORD: the halt word is latched into FD as a normal instruction, pc is NOT incremented, next state is HALT.

State HALT:
- halted=1; pc frozen.
- On the first edge, FD<=NOP_WORD, fd_valid<=0; FD stays NOP after that.
- Counters do not increment.
- redirect=1 (an older branch resolving): performs the redirect action above, including flush_cycles++, clears halted, next state RUN.
- Stall inputs are ignored in HALT.

Counters:
- 16-bit, saturate at 16'hFFFF; no wrap.

Latency:
- Instruction at imem_addr appears on fd_inst one edge later.
- Redirect target is fetched on the edge after the redirect edge, so it appears in FD two edges after redirect is asserted.

Test Plan:
- Release reset, imem returns addr+100, no stalls -> first edge: fd_valid=0 (BOOT); next edges: fd_inst=100,101,102, fd_pc=1,2,3, imem_addr=1,2,3.
- Assert control_stall for 3 cycles at pc=5 -> imem_addr stays 5, fd_inst/fd_pc frozen, stall_cycles=3; release -> fd_inst=105.
- redirect=1 with redirect_pc=0x040 while control_stall=1 -> next edge: imem_addr=0x040, fd_inst=0, fd_valid=0, flush_cycles=1, stall_cycles unchanged; following edge: fd_inst=imem[0x040], fd_pc=0x041.
- pc=0xFFF, advance -> imem_addr=0x000, fd_pc=0x000 (wrap).
- HALT_WORD at pc=7 -> fd_inst=FFFFFFFF, then NOP, halted=1, imem_addr stays 7 for 10 cycles, counters frozen; redirect to 0x010 -> halted=0, fetch resumes at 0x010.
- Hold multdiv_busy for 70000 cycles -> stall_cycles=16'hFFFF (saturated); pull reset low mid-stall -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_fd_latch.sv
// IF stage and F/D pipeline latch: owns the PC, applies redirect/hold/advance
// each cycle, stops fetch on the halt encoding, and keeps saturating stall/flush counters.
module fetch_fd_latch #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_WORD  = 32'h0000_0000,
  parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_inst,
  input  logic              control_stall,
  input  logic              multdiv_busy,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fd_inst,
  output logic [ADDR_W-1:0] fd_pc,
  output logic              fd_valid,
  output logic              halted,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_cycles
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fd_pc_q, fd_pc_d;
  logic [31:0]       fd_inst_q, fd_inst_d;
  logic              fd_valid_q, fd_valid_d;
  logic [15:0]       stall_q, stall_d;
  logic [15:0]       flush_q, flush_d;
  logic              stall_inc, flush_inc;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fd_pc_d    = fd_pc_q;
    fd_inst_d  = fd_inst_q;
    fd_valid_d = fd_valid_q;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HALT: begin
        if (redirect) begin
          // A redirect wins over holds and also pulls fetch out of HALT.
          pc_d       = redirect_pc;
          fd_inst_d  = NOP_WORD;
          fd_pc_d    = '0;
          fd_valid_d = 1'b0;
          flush_inc  = 1'b1;
          state_d    = RUN;
        end else if (state_q == HALT) begin
          fd_inst_d  = NOP_WORD;
          fd_pc_d    = '0;
          fd_valid_d = 1'b0;
        end else if (control_stall || multdiv_busy) begin
          stall_inc = 1'b1;
        end else begin
          fd_inst_d  = imem_inst;
          fd_pc_d    = pc_inc;
          fd_valid_d = 1'b1;
          // The halt word itself still enters FD; only the PC stops.
          if (imem_inst == HALT_WORD) state_d = HALT;
          else                        pc_d    = pc_inc;
        end
      end
      default: state_d = BOOT;
    endcase
    stall_d = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    flush_d = (flush_inc && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      fd_pc_q    <= '0;
      fd_inst_q  <= NOP_WORD;
      fd_valid_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_pc_q    <= fd_pc_d;
      fd_inst_q  <= fd_inst_d;
      fd_valid_q <= fd_valid_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign imem_addr    = pc_q;
  assign fd_inst      = fd_inst_q;
  assign fd_pc        = fd_pc_q;
  assign fd_valid     = fd_valid_q;
  assign halted       = (state_q == HALT);
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;

endmodule

// File: tb/tb_fetch_fd_latch.sv
// Bench for fetch_fd_latch: a cycle-level reference model checked every negedge,
// plus directed sequences with hand-computed literal expectations.
module tb_fetch_fd_latch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_inst;
  logic        control_stall = 1'b0, multdiv_busy = 1'b0, redirect = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic [31:0] fd_inst;
  logic [11:0] fd_pc;
  logic        fd_valid, halted;
  logic [15:0] stall_cycles, flush_cycles;

  fetch_fd_latch dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .control_stall(control_stall), .multdiv_busy(multdiv_busy),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fd_inst(fd_inst), .fd_pc(fd_pc), .fd_valid(fd_valid), .halted(halted),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clock = ~clock;

  // Instruction memory: word = address + 100, except an optional halt location.
  logic        halt_en = 1'b0;
  logic [11:0] halt_addr = '0;
  function automatic logic [31:0] mem(input logic [11:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    return 32'(a) + 32'd100;
  endfunction
  always_comb imem_inst = mem(imem_addr);

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=boot 1=run 2=halted.
  int m_mode, m_pc, m_fdpc, m_stall, m_flush;
  logic [31:0] m_inst;
  bit m_valid;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_pc = 0; m_fdpc = 0; m_inst = 0; m_valid = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (redirect) begin
      m_pc = redirect_pc; m_inst = 0; m_valid = 0; m_fdpc = 0;
      if (m_flush < 65535) m_flush = m_flush + 1;
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_inst = 0; m_valid = 0;
    end else if (control_stall || multdiv_busy) begin
      if (m_stall < 65535) m_stall = m_stall + 1;
    end else begin
      m_inst = mem(12'(m_pc)); m_valid = 1; m_fdpc = (m_pc + 1) % 4096;
      if (m_inst == 32'hFFFF_FFFF) m_mode = 2;
      else m_pc = (m_pc + 1) % 4096;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("m_addr",   imem_addr,    64'(m_pc));
      chk("m_inst",   fd_inst,      64'(m_inst));
      chk("m_valid",  fd_valid,     64'(m_valid));
      chk("m_halted", halted,       64'(m_mode == 2));
      chk("m_stall",  stall_cycles, 64'(m_stall));
      chk("m_flush",  flush_cycles, 64'(m_flush));
      if (m_mode != 2) chk("m_fdpc", fd_pc, 64'(m_fdpc));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    tick(2);
    chk("rst_addr", imem_addr, 0);
    chk("rst_inst", fd_inst, 0);
    chk("rst_valid", fd_valid, 0);
    chk("rst_cnt", {stall_cycles, flush_cycles}, 0);
    reset = 1'b1;
    tick();                                   // boot edge
    chk("boot_valid", fd_valid, 0);
    chk("boot_addr", imem_addr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("adv_inst", fd_inst, 100 + i);
      chk("adv_fdpc", fd_pc, 1 + i);
      chk("adv_addr", imem_addr, 1 + i);
      chk("adv_valid", fd_valid, 1);
    end
    tick(2);
    chk("pre_stall_addr", imem_addr, 5);
    control_stall = 1'b1;
    tick(3);
    chk("stall_addr", imem_addr, 5);
    chk("stall_inst", fd_inst, 104);
    chk("stall_fdpc", fd_pc, 5);
    chk("stall_cnt", stall_cycles, 3);
    control_stall = 1'b0;
    tick();
    chk("unstall_inst", fd_inst, 105);
    // Redirect overrides a simultaneous stall.
    control_stall = 1'b1; redirect = 1'b1; redirect_pc = 12'h040;
    tick();
    chk("redir_addr", imem_addr, 12'h040);
    chk("redir_inst", fd_inst, 0);
    chk("redir_valid", fd_valid, 0);
    chk("redir_flush", flush_cycles, 1);
    chk("redir_stall", stall_cycles, 3);
    control_stall = 1'b0; redirect = 1'b0;
    tick();
    chk("redir_tgt_inst", fd_inst, 32'h40 + 100);
    chk("redir_tgt_fdpc", fd_pc, 12'h041);
    // PC wrap.
    redirect = 1'b1; redirect_pc = 12'hFFF;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_addr", imem_addr, 0);
    chk("wrap_fdpc", fd_pc, 0);
    chk("wrap_inst", fd_inst, 32'hFFF + 100);
    // Halt at pc 7; stall inputs must be ignored while halted.
    halt_en = 1'b1; halt_addr = 12'd7;
    redirect = 1'b1; redirect_pc = 12'd5;
    tick();
    redirect = 1'b0;
    tick(3);
    chk("halt_inst", fd_inst, 32'hFFFF_FFFF);
    chk("halt_flag", halted, 1);
    chk("halt_addr", imem_addr, 7);
    control_stall = 1'b1;
    tick();
    chk("halt_nop", fd_inst, 0);
    chk("halt_nop_valid", fd_valid, 0);
    tick(10);
    chk("halt_hold_addr", imem_addr, 7);
    chk("halt_cnts", {stall_cycles, flush_cycles}, {16'd3, 16'd3});
    control_stall = 1'b0; redirect = 1'b1; redirect_pc = 12'h010;
    tick();
    chk("unhalt_flag", halted, 0);
    chk("unhalt_addr", imem_addr, 12'h010);
    chk("unhalt_flush", flush_cycles, 4);
    redirect = 1'b0; halt_en = 1'b0;
    tick();
    chk("resume_inst", fd_inst, 32'h10 + 100);
    chk("resume_fdpc", fd_pc, 12'h011);
    // Saturation, then asynchronous reset mid-stall.
    multdiv_busy = 1'b1;
    tick(70000);
    chk("sat_stall", stall_cycles, 16'hFFFF);
    #2 reset = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 0);
    chk("arst_inst", fd_inst, 0);
    chk("arst_fdpc", fd_pc, 0);
    chk("arst_valid", fd_valid, 0);
    chk("arst_halted", halted, 0);
    chk("arst_cnt", {stall_cycles, flush_cycles}, 0);
    multdiv_busy = 1'b0;
    tick();
    reset = 1'b1;
    tick(3);
    chk("post_rst_inst", fd_inst, 101);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
